// File: rtl/picomips_pkg.sv
// -----------------------------------------------------------------------------
// picomips_pkg
// Shared ISA definitions for the picoMIPS core: opcode encoding, sequencer
// state encoding, ALU function codes and the default multiply latency.
// Used by the sequencer, the ALU and the instruction decoder.
// -----------------------------------------------------------------------------
package picomips_pkg;

  // Opcode field width. The ISA encoding fixes it.
  localparam int OPC_W = 3;

  // Default number of cycles spent in the MULT state. Legal range is 1..15.
  localparam int MUL_LAT_DEF = 2;

  typedef enum logic [OPC_W-1:0] {
    OPC_ADD  = 3'd0,
    OPC_ADDI = 3'd1,
    OPC_SUB  = 3'd2,
    OPC_MULI = 3'd3,
    OPC_MUL  = 3'd4,
    OPC_IN   = 3'd5,
    OPC_OUT  = 3'd6,
    OPC_HALT = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_EXEC       = 3'd1,
    ST_MULT       = 3'd2,
    ST_WAIT_PRESS = 3'd3,
    ST_WAIT_REL   = 3'd4,
    ST_HALT       = 3'd5
  } seq_state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_MUL   = 3'd2,
    ALU_PASSB = 3'd3
  } alu_op_t;

  // Bundle of every control output the sequencer decodes in one cycle.
  typedef struct packed {
    logic    pc_inc;
    logic    rf_we;
    logic    out_we;
    logic    imm_sel;
    logic    in_sel;
    alu_op_t alu_op;
  } seq_ctrl_t;

endpackage : picomips_pkg

// File: rtl/picomips_seq.sv
// -----------------------------------------------------------------------------
// picomips_seq
// Multi-cycle instruction sequencer for picoMIPS. Latches the opcode read
// from program memory, steps through multi-cycle execution (multiply,
// input-switch handshake, halt) and generates the one-cycle PC increment
// and write strobes. All control outputs are a combinational decode of the
// registered state (plus in_valid for the switch handshake); the live
// opcode input is only ever sampled into ir.
//
// Configuration:
//   PICOMIPS_SINGLE_STEP_EN  when defined, adds the 'step' input and FETCH
//                            waits for a step pulse before loading ir.
//
// Ports:
//   clk       in   system clock, rising edge
//   nRst      in   asynchronous active-low reset
//   opcode    in   opcode field of the program word at the current PC
//   in_valid  in   synchronised switch level, 1 = data ready
//   step      in   single-step pulse (PICOMIPS_SINGLE_STEP_EN only)
//   pc_inc    out  one-cycle program counter increment
//   rf_we     out  register-file write enable
//   alu_op    out  ALU function (add, sub, mul, pass-B)
//   imm_sel   out  ALU B operand = immediate field
//   in_sel    out  write-back source = switch input
//   out_we    out  output-port register load
//   busy      out  instruction in progress (not FETCH, not HALT)
//   halted    out  HALT executed
// -----------------------------------------------------------------------------
module picomips_seq
  import picomips_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             in_valid,
`ifdef PICOMIPS_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             pc_inc,
  output logic             rf_we,
  output logic [2:0]       alu_op,
  output logic             imm_sel,
  output logic             in_sel,
  output logic             out_we,
  output logic             busy,
  output logic             halted
);

  // MULT counts down from MUL_LAT-1 to 0, so it lasts exactly MUL_LAT cycles.
  localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 1);

  seq_state_t state_q;
  opcode_t    ir_q;
  logic [3:0] mcnt_q;
  logic       fetch_go;
  seq_ctrl_t  ctrl;

`ifdef PICOMIPS_SINGLE_STEP_EN
  // Step pulses outside FETCH are simply not looked at.
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // NOTE: state lives in one clocked block with non-blocking assignments so
  // every register updates from the same pre-edge values; the asynchronous
  // reset drops the machine into FETCH at once, cancelling any strobe.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_FETCH;
      ir_q    <= OPC_ADD;
      mcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (fetch_go) begin
            ir_q    <= opcode_t'(opcode);
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (ir_q)
            OPC_ADD, OPC_ADDI, OPC_SUB, OPC_OUT: state_q <= ST_FETCH;
            OPC_MUL, OPC_MULI: begin
              mcnt_q  <= MCNT_INIT;
              state_q <= ST_MULT;
            end
            OPC_IN:   state_q <= ST_WAIT_PRESS;
            default:  state_q <= ST_HALT;
          endcase
        end
        ST_MULT: begin
          if (mcnt_q == 4'd0) state_q <= ST_FETCH;
          else                mcnt_q  <= mcnt_q - 4'd1;
        end
        // Accept on the first cycle in_valid is seen high, then wait for the
        // release so a single press can never yield two IN results.
        ST_WAIT_PRESS: if (in_valid)  state_q <= ST_WAIT_REL;
        ST_WAIT_REL:   if (!in_valid) state_q <= ST_FETCH;
        ST_HALT:       state_q <= ST_HALT;
        default:       state_q <= ST_FETCH;
      endcase
    end
  end

  // NOTE: every field is defaulted before the case so no path leaves an
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl = '{pc_inc: 1'b0, rf_we: 1'b0, out_we: 1'b0, imm_sel: 1'b0,
             in_sel: 1'b0, alu_op: ALU_ADD};
    case (state_q)
      ST_EXEC: begin
        case (ir_q)
          OPC_ADD: begin
            ctrl.rf_we  = 1'b1;
            ctrl.pc_inc = 1'b1;
          end
          OPC_ADDI: begin
            ctrl.rf_we   = 1'b1;
            ctrl.pc_inc  = 1'b1;
            ctrl.imm_sel = 1'b1;
          end
          OPC_SUB: begin
            ctrl.rf_we  = 1'b1;
            ctrl.pc_inc = 1'b1;
            ctrl.alu_op = ALU_SUB;
          end
          OPC_OUT: begin
            ctrl.out_we = 1'b1;
            ctrl.pc_inc = 1'b1;
            ctrl.alu_op = ALU_PASSB;
          end
          default: ;
        endcase
      end
      ST_MULT: begin
        ctrl.alu_op  = ALU_MUL;
        ctrl.imm_sel = (ir_q == OPC_MULI);
        if (mcnt_q == 4'd0) begin
          ctrl.rf_we  = 1'b1;
          ctrl.pc_inc = 1'b1;
        end
      end
      ST_WAIT_PRESS: begin
        if (in_valid) begin
          ctrl.rf_we  = 1'b1;
          ctrl.in_sel = 1'b1;
          ctrl.alu_op = ALU_PASSB;
          ctrl.pc_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pc_inc  = ctrl.pc_inc;
  assign rf_we   = ctrl.rf_we;
  assign out_we  = ctrl.out_we;
  assign imm_sel = ctrl.imm_sel;
  assign in_sel  = ctrl.in_sel;
  assign alu_op  = ctrl.alu_op;
  assign busy    = (state_q != ST_FETCH) && (state_q != ST_HALT);
  assign halted  = (state_q == ST_HALT);

endmodule : picomips_seq

// File: tb/tb_picomips_seq.sv
// -----------------------------------------------------------------------------
// tb_picomips_seq
// Self-checking bench for picomips_seq. A small program memory and PC model
// feed opcodes; a planner derives, from instruction timing rules, the cycle
// and strobe values of every pc_inc plus per-cycle busy/halted. Expected
// pc_inc records enter a scoreboard as each instruction is issued; a monitor
// on the falling edge pops and compares them.
// Set PICOMIPS_SINGLE_STEP_EN to exercise the single-step build.
// -----------------------------------------------------------------------------
module tb_picomips_seq;
  import picomips_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int MAXC    = 2048;

  typedef struct {
    int          start;
    int          cyc;
    logic        rf_we;
    logic        out_we;
    logic        in_sel;
    logic        imm_sel;
    logic [2:0]  alu;
  } exp_t;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       in_valid = 1'b0;
`ifdef PICOMIPS_SINGLE_STEP_EN
  logic       step = 1'b0;
  bit         step_plan [MAXC];
`endif
  logic       pc_inc, rf_we, imm_sel, in_sel, out_we, busy, halted;
  logic [2:0] alu_op;

  int         cyc;
  logic [7:0] pc;
  opcode_t    prog [256];
  int         n_prog;
  bit         iv_plan   [MAXC];
  bit         busy_plan [MAXC];
  bit         halt_plan [MAXC];
  int         halt_start;
  int         s_next;
  exp_t       plan_q [$];
  exp_t       sb [$];
  int         push_idx;
  int         n_checks = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  picomips_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .opcode   (opcode),
    .in_valid (in_valid),
`ifdef PICOMIPS_SINGLE_STEP_EN
    .step     (step),
`endif
    .pc_inc   (pc_inc),
    .rf_we    (rf_we),
    .alu_op   (alu_op),
    .imm_sel  (imm_sel),
    .in_sel   (in_sel),
    .out_we   (out_we),
    .busy     (busy),
    .halted   (halted)
  );

  // Environment: cycle index since reset release, and the program counter
  // the sequencer drives.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge clk or negedge nRst) begin
    if (!nRst)       pc <= 8'd0;
    else if (pc_inc) pc <= pc + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_alu(input opcode_t op);
    case (op)
      OPC_SUB:           return 3'd1;
      OPC_MUL, OPC_MULI: return 3'd2;
      OPC_IN, OPC_OUT:   return 3'd3;
      default:           return 3'd0;
    endcase
  endfunction

  task automatic begin_phase();
    s_next = 0;
    n_prog = 0;
    halt_start = MAXC;
    plan_q.delete();
    for (int c = 0; c < MAXC; c++) begin
      iv_plan[c]   = 1'b0;
      busy_plan[c] = 1'b0;
      halt_plan[c] = 1'b0;
`ifdef PICOMIPS_SINGLE_STEP_EN
      step_plan[c] = 1'b1;
`endif
    end
    for (int i = 0; i < 256; i++) prog[i] = OPC_HALT;
  endtask

  // Timing rules: ALU/OUT take 2 cycles with pc_inc in the 2nd; MUL/MULI
  // take 2+MUL_LAT with pc_inc in the last; IN with d idle cycles and h held
  // cycles takes 3+d+h with pc_inc on the first high cycle; HALT halts from
  // its 3rd cycle on.
  task automatic add_instr(input opcode_t op, input int d, input int h);
    exp_t e;
    int   dur;
    prog[n_prog] = op;
    n_prog++;
    e.start   = s_next;
    e.alu     = exp_alu(op);
    e.rf_we   = (op != OPC_OUT);
    e.out_we  = (op == OPC_OUT);
    e.imm_sel = (op == OPC_ADDI) || (op == OPC_MULI);
    e.in_sel  = (op == OPC_IN);
    case (op)
      OPC_MUL, OPC_MULI: begin dur = 2 + MUL_LAT; e.cyc = s_next + 1 + MUL_LAT; end
      OPC_IN:            begin dur = 3 + d + h;   e.cyc = s_next + 2 + d;       end
      OPC_HALT:          begin dur = 0;           e.cyc = 0;                    end
      default:           begin dur = 2;           e.cyc = s_next + 1;           end
    endcase
    if (op == OPC_HALT) begin
      busy_plan[s_next + 1] = 1'b1;
      halt_start = s_next + 2;
      for (int c = s_next; c < MAXC; c++) begin
        iv_plan[c] = 1'($urandom);
        if (c >= halt_start) halt_plan[c] = 1'b1;
      end
    end else begin
      for (int c = s_next; c < s_next + dur; c++) begin
        iv_plan[c]   = 1'($urandom);
        busy_plan[c] = (c != s_next);
      end
      if (op == OPC_IN) begin
        for (int c = s_next + 2; c < s_next + 2 + d; c++) iv_plan[c] = 1'b0;
        for (int c = s_next + 2 + d; c < s_next + 2 + d + h; c++) iv_plan[c] = 1'b1;
        iv_plan[s_next + 2 + d + h] = 1'b0;
      end
      plan_q.push_back(e);
      s_next += dur;
    end
  endtask

  // Apply inputs for the current cycle and issue expectations for every
  // instruction whose FETCH starts now.
  task automatic apply();
    in_valid = iv_plan[cyc];
    opcode   = (cyc >= halt_start) ? 3'($urandom) : prog[pc];
`ifdef PICOMIPS_SINGLE_STEP_EN
    step     = step_plan[cyc];
`endif
    while (push_idx < plan_q.size() && plan_q[push_idx].start <= cyc) begin
      sb.push_back(plan_q[push_idx]);
      push_idx++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (nRst) apply();
    end
  end

  // Monitor: compare per-cycle status and pop the scoreboard on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nRst) begin
        check("busy", busy, busy_plan[cyc]);
        check("halted", halted, halt_plan[cyc]);
        check("rf_we_out_we_excl", rf_we & out_we, 0);
        if (sb.size() > 0 && cyc >= sb[0].cyc) begin
          e = sb.pop_front();
          check("pc_inc_due", pc_inc, 1);
          check("rf_we", rf_we, e.rf_we);
          check("out_we", out_we, e.out_we);
          check("in_sel", in_sel, e.in_sel);
          check("imm_sel", imm_sel, e.imm_sel);
          check("alu_op", alu_op, e.alu);
        end else begin
          check("pc_inc_idle", pc_inc, 0);
          check("strobe_idle", {rf_we, out_we}, 0);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_pc_inc"}, pc_inc, 0);
    check({tag, "_rf_we"}, rf_we, 0);
    check({tag, "_out_we"}, out_we, 0);
    check({tag, "_in_sel"}, in_sel, 0);
    check({tag, "_imm_sel"}, imm_sel, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  task automatic assert_rst();
    nRst = 1'b0;
    sb.delete();
    push_idx = 0;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    push_idx = 0;
    apply();
    nRst = 1'b1;
  endtask

  task automatic run_to(input int stop);
    for (int k = 0; k < MAXC && cyc < stop; k++) @(negedge clk);
  endtask

  initial begin
    opcode_t op;
    int      r;
    #1;
    check_zero("reset");

    // Directed opening, then a random instruction mix, then HALT.
    begin_phase();
    add_instr(OPC_ADD, 0, 1);
    add_instr(OPC_ADDI, 0, 1);
    add_instr(OPC_SUB, 0, 1);
    add_instr(OPC_OUT, 0, 1);
    add_instr(OPC_MUL, 0, 1);
    add_instr(OPC_MULI, 0, 1);
    add_instr(OPC_IN, 10, 5);
    add_instr(OPC_IN, 0, 1);
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 6);
      op = opcode_t'(r);
      add_instr(op, $urandom_range(0, 4), $urandom_range(1, 4));
    end
    add_instr(OPC_HALT, 0, 1);
    release_rst();
    run_to(halt_start + 20);
    check("drained_free_run", sb.size(), 0);
    #2;
    assert_rst();
    #1;
    check_zero("rst_from_halt");

    // Reset while in MULT with mcnt==1.
    begin_phase();
    add_instr(OPC_MUL, 0, 1);
    add_instr(OPC_ADD, 0, 1);
    add_instr(OPC_HALT, 0, 1);
    release_rst();
    run_to(2);
    check("mult_alu_before_rst", alu_op, 2);
    #2;
    assert_rst();
    #1;
    check_zero("rst_in_mult");

    // Reset while in WAIT_REL with the switch still held.
    begin_phase();
    add_instr(OPC_ADD, 0, 1);
    add_instr(OPC_IN, 1, 3);
    add_instr(OPC_HALT, 0, 1);
    release_rst();
    run_to(6);
    check("wait_rel_busy_before_rst", busy, 1);
    #2;
    assert_rst();
    #1;
    check_zero("rst_in_wait_rel");

    // Clean restart: no stale strobe may appear.
    begin_phase();
    add_instr(OPC_ADD, 0, 1);
    add_instr(OPC_ADDI, 0, 1);
    add_instr(OPC_MULI, 0, 1);
    add_instr(OPC_HALT, 0, 1);
    release_rst();
    run_to(halt_start + 3);
    check("drained_restart", sb.size(), 0);

`ifdef PICOMIPS_SINGLE_STEP_EN
    // One ADD per step pulse; a pulse during EXEC is ignored.
    #2;
    assert_rst();
    begin_phase();
    for (int c = 0; c < MAXC; c++) step_plan[c] = 1'b0;
    step_plan[2]  = 1'b1;
    step_plan[3]  = 1'b1;
    step_plan[7]  = 1'b1;
    step_plan[12] = 1'b1;
    step_plan[17] = 1'b1;
    s_next = 2;  add_instr(OPC_ADD, 0, 1);
    s_next = 7;  add_instr(OPC_ADD, 0, 1);
    s_next = 12; add_instr(OPC_ADD, 0, 1);
    s_next = 17; add_instr(OPC_HALT, 0, 1);
    release_rst();
    run_to(23);
    check("drained_step", sb.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_picomips_seq
